// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: ordered, retrying power-up register writes to the audio codec
// over the shared I2C master. Define CODEC_VOLUME_EN to add headphone volume updates.
module codec_config_sequencer #(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int RETRY_MAX      = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        i2c_start,
  output logic [15:0] i2c_word,
  input  logic        i2c_done,
  input  logic        i2c_ack,
`ifdef CODEC_VOLUME_EN
  input  logic        vol_req,
  input  logic [6:0]  vol_level,
`endif
  output logic        stream_enable,
  output logic        config_error,
  output logic [3:0]  reg_index
);
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM   = RW'(RETRY_MAX);

  // Handshake: i2c_start is a one-cycle request carrying i2c_word; the master answers with
  // one i2c_done pulse, i2c_ack valid only alongside it. Done pulses outside WAIT are dropped.
  typedef enum logic [2:0] {S_SETTLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_ERROR} state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [RW-1:0] retry_cnt;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tout_cnt;
  logic          ack_q;

  function automatic logic [15:0] table_word(input logic [3:0] i);
    case (i)
      4'd0:    table_word = 16'h1E00;
      4'd1:    table_word = 16'h0C00;
      4'd2:    table_word = 16'h0812;
      4'd3:    table_word = 16'h0A00;
      4'd4:    table_word = 16'h0E23;
      4'd5:    table_word = 16'h102F;
      4'd6:    table_word = 16'h0460;
      4'd7:    table_word = 16'h0660;
      default: table_word = 16'h1201;
    endcase
  endfunction

`ifdef CODEC_VOLUME_EN
  logic       vol_active, vol_second, vol_pend;
  logic [6:0] vol_val, vol_pend_val, vol_next;

  // Left (reg 0x02) or right (reg 0x03) headphone volume, update bit set.
  function automatic logic [15:0] vol_word(input logic right, input logic [6:0] v);
    vol_word = {(right ? 7'h03 : 7'h02), 2'b10, v};
  endfunction

  assign vol_next = vol_req ? vol_level : vol_pend_val;
`endif

  assign reg_index = idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_SETTLE;
      idx           <= 4'd0;
      retry_cnt     <= '0;
      settle_cnt    <= '0;
      tout_cnt      <= '0;
      ack_q         <= 1'b0;
      i2c_start     <= 1'b0;
      i2c_word      <= 16'h1E00;
      stream_enable <= 1'b0;
      config_error  <= 1'b0;
`ifdef CODEC_VOLUME_EN
      vol_active    <= 1'b0;
      vol_second    <= 1'b0;
      vol_pend      <= 1'b0;
      vol_val       <= 7'd0;
      vol_pend_val  <= 7'd0;
`endif
    end else begin
      i2c_start <= 1'b0;
`ifdef CODEC_VOLUME_EN
      if (vol_req && vol_active) begin
        vol_pend     <= 1'b1;
        vol_pend_val <= vol_level;
      end
`endif
      case (state)
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state     <= S_ISSUE;
            i2c_start <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          tout_cnt <= '0;
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle still counts as a completed transfer.
          if (i2c_done) begin
            ack_q <= i2c_ack;
            state <= S_CHECK;
          end else if (tout_cnt == TOUT_LAST) begin
            ack_q <= 1'b0;
            state <= S_CHECK;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (!ack_q) begin
            if (retry_cnt < RETRY_LIM) begin
              retry_cnt <= retry_cnt + 1'b1;
              i2c_start <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              state         <= S_ERROR;
              config_error  <= 1'b1;
              stream_enable <= 1'b0;
`ifdef CODEC_VOLUME_EN
              vol_active    <= 1'b0;
              vol_pend      <= 1'b0;
`endif
            end
          end else begin
            retry_cnt <= '0;
`ifdef CODEC_VOLUME_EN
            if (vol_active) begin
              if (!vol_second) begin
                vol_second <= 1'b1;
                idx        <= 4'd7;
                i2c_word   <= vol_word(1'b1, vol_val);
                i2c_start  <= 1'b1;
                state      <= S_ISSUE;
              end else begin
                vol_active <= 1'b0;
                idx        <= 4'd8;
                state      <= S_DONE;
              end
            end else
`endif
            if (idx == 4'd8) begin
              state         <= S_DONE;
              stream_enable <= 1'b1;
            end else if (idx == 4'd0) begin
              // The codec needs another settle period after its soft reset.
              idx        <= 4'd1;
              i2c_word   <= table_word(4'd1);
              settle_cnt <= '0;
              state      <= S_SETTLE;
            end else begin
              idx       <= idx + 4'd1;
              i2c_word  <= table_word(idx + 4'd1);
              i2c_start <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            state         <= S_SETTLE;
            idx           <= 4'd0;
            retry_cnt     <= '0;
            settle_cnt    <= '0;
            i2c_word      <= 16'h1E00;
            stream_enable <= 1'b0;
            config_error  <= 1'b0;
`ifdef CODEC_VOLUME_EN
            vol_pend      <= 1'b0;
`endif
          end
`ifdef CODEC_VOLUME_EN
          else if (state == S_DONE && (vol_req || vol_pend)) begin
            vol_active <= 1'b1;
            vol_second <= 1'b0;
            vol_pend   <= 1'b0;
            vol_val    <= vol_next;
            idx        <= 4'd6;
            i2c_word   <= vol_word(1'b0, vol_next);
            retry_cnt  <= '0;
            i2c_start  <= 1'b1;
            state      <= S_ISSUE;
          end
`endif
        end
        default: state <= S_SETTLE;
      endcase
    end
  end
endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: scenario table plus hand sequences for timing corners,
// with an I2C master model and an expected-word scoreboard.
`timescale 1ns/1ps
module tb_codec_config_sequencer;
  localparam int SETTLE  = 20;
  localparam int RETRIES = 3;
  localparam int TOUT    = 100;
  localparam int DELAY   = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        i2c_start, i2c_done, i2c_ack, stream_enable, config_error;
  logic [15:0] i2c_word;
  logic [3:0]  reg_index;
`ifdef CODEC_VOLUME_EN
  logic        vol_req = 1'b0;
  logic [6:0]  vol_level = 7'd0;
`endif

  codec_config_sequencer #(
    .SETTLE_CYCLES(SETTLE), .RETRY_MAX(RETRIES), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .i2c_start(i2c_start), .i2c_word(i2c_word), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
`ifdef CODEC_VOLUME_EN
    .vol_req(vol_req), .vol_level(vol_level),
`endif
    .stream_enable(stream_enable), .config_error(config_error), .reg_index(reg_index)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int rst_cyc = 0;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int          st_cyc[$];
  int          dn_cyc[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tbl [9] = '{16'h1E00, 16'h0C00, 16'h0812, 16'h0A00, 16'h0E23,
                           16'h102F, 16'h0460, 16'h0660, 16'h1201};

  // ---------------- I2C master model ----------------
  logic [15:0] bad_word = 16'hFFFF;
  int          bad_left = 0;
  bit          bad_drop = 1'b0;
  bit          keep_stale = 1'b0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [15:0] cur = 16'h0;

  initial begin : i2c_model
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_ack  = 1'b0;
      if (reset && !keep_stale) begin
        busy = 1'b0;
      end else if (busy) begin
        if (cnt == 0) begin
          busy     = 1'b0;
          i2c_done = 1'b1;
          i2c_ack  = 1'b1;
          if (!bad_drop && cur == bad_word && bad_left > 0) begin
            i2c_ack  = 1'b0;
            bad_left = bad_left - 1;
          end
          dn_cyc.push_back(cyc);
        end else begin
          cnt = cnt - 1;
        end
      end else if (i2c_start === 1'b1 && !reset) begin
        if (bad_drop && i2c_word == bad_word && bad_left > 0) begin
          bad_left = bad_left - 1;
        end else begin
          busy = 1'b1;
          cnt  = DELAY;
          cur  = i2c_word;
        end
      end
    end
  end

  // ---------------- monitor: every request is popped against the expected queue ----------------
  initial begin : monitor
    logic [15:0] exp_w;
    forever begin
      @(negedge clk);
      if (i2c_start === 1'b1) begin
        st_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start actual=%h required=none", i2c_word);
        end else begin
          exp_w = exp_q.pop_front();
          if (i2c_word !== exp_w) begin
            errors++;
            $display("FAIL i2c_word actual=%h required=%h", i2c_word, exp_w);
          end
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int get_st(input int i);
    return (st_cyc.size() > i) ? st_cyc[i] : -100000;
  endfunction

  function automatic int get_dn(input int i);
    return (dn_cyc.size() > i) ? dn_cyc[i] : -100000;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    rst_cyc = cyc;
    exp_q.delete();
    st_cyc.delete();
    dn_cyc.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_i2c_start"}, int'(i2c_start), 0);
    chk({tag, "_i2c_word"}, int'(i2c_word), 16'h1E00);
    chk({tag, "_stream"}, int'(stream_enable), 0);
    chk({tag, "_error"}, int'(config_error), 0);
    chk({tag, "_reg_index"}, int'(reg_index), 0);
  endtask

  task automatic set_bad(input int bad_idx, input int times, input bit drop);
    bad_word = 16'hFFFF;
    if (bad_idx >= 0 && bad_idx < 9) bad_word = tbl[bad_idx];
    bad_left = times;
    bad_drop = drop;
  endtask

  // Expected request stream: each write once, the faulty one retried up to RETRIES times.
  task automatic push_run(input int bad_idx, input int bad_times);
    for (int i = 0; i < 9; i++) begin
      int att;
      att = (i == bad_idx) ? bad_times + 1 : 1;
      if (att > RETRIES + 1) att = RETRIES + 1;
      for (int a = 0; a < att; a++) exp_q.push_back(tbl[i]);
      if (i == bad_idx && bad_times > RETRIES) break;
    end
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!(stream_enable === 1'b1 || config_error === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required=<%0d", name, n, budget);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    int         bad_idx;
    int         bad_times;
    bit         drop;
    bit         exp_err;
    bit         exp_stream;
    logic [3:0] exp_reg;
  } scen_t;

  // ---------------- main sequence ----------------
  initial begin : main
    scen_t scen[6];
    int    ref_c;
    int    n;
    scen[0] = '{-1, 0, 1'b0, 1'b0, 1'b1, 4'd8};  // clean run
    scen[1] = '{ 3, 2, 1'b0, 1'b0, 1'b1, 4'd8};  // two NACKs then ACK
    scen[2] = '{ 5, 9, 1'b0, 1'b1, 1'b0, 4'd5};  // NACK forever
    scen[3] = '{ 0, 1, 1'b0, 1'b0, 1'b1, 4'd8};  // retry of reset write
    scen[4] = '{ 8, 3, 1'b0, 1'b0, 1'b1, 4'd8};  // exactly RETRY_MAX retries on last write
    scen[5] = '{ 2, 4, 1'b1, 1'b1, 1'b0, 4'd2};  // no i2c_done at all -> timeouts

    for (int s = 0; s < 6; s++) begin
      set_bad(scen[s].bad_idx, scen[s].bad_times, scen[s].drop);
      do_reset();
      chk_reset_vals($sformatf("s%0d_reset", s));
      push_run(scen[s].bad_idx, scen[s].bad_times);
      wait_end($sformatf("s%0d", s), 3000);
      repeat (5) @(negedge clk);
      chk($sformatf("s%0d_error", s), int'(config_error), int'(scen[s].exp_err));
      chk($sformatf("s%0d_stream", s), int'(stream_enable), int'(scen[s].exp_stream));
      chk($sformatf("s%0d_reg_index", s), int'(reg_index), int'(scen[s].exp_reg));
      chk($sformatf("s%0d_leftover", s), exp_q.size(), 0);
      if (s == 0) begin
        chk("first_start_latency", get_st(0) - rst_cyc, SETTLE + 1);
        chk("settle_gap_after_idx0", get_st(1) - get_dn(0), SETTLE + 3);
        chk("issue_gap_after_done", get_st(2) - get_dn(1), 2);
      end
      if (s == 5) begin
        chk("timeout_retry_gap", get_st(3) - get_st(2), TOUT + 2);
        set_bad(-1, 0, 1'b0);
        st_cyc.delete();
        dn_cyc.delete();
        push_run(-1, 0);
        pulse_start();
        ref_c = cyc;
        chk("restart_error_clear", int'(config_error), 0);
        wait_end("restart", 3000);
        chk("restart_latency", get_st(0) - ref_c, SETTLE + 1);
        repeat (5) @(negedge clk);
        chk("restart_stream", int'(stream_enable), 1);
        chk("restart_leftover", exp_q.size(), 0);
      end
    end

    // Reset while waiting on index 6; the master's late done must be ignored.
    set_bad(-1, 0, 1'b0);
    do_reset();
    push_run(-1, 0);
    n = 0;
    while (st_cyc.size() < 7 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx6", int'(st_cyc.size() >= 7), 1);
    ref_c = get_st(6);
    while (cyc < ref_c + 10 && n < 4000) begin @(negedge clk); n++; end
    pulse_start();
    while (cyc < ref_c + 35 && n < 4000) begin @(negedge clk); n++; end
    chk("start_ignored_idx", int'(reg_index), 6);
    keep_stale = 1'b1;
    do_reset();
    chk_reset_vals("midwait_reset");
    push_run(-1, 0);
    wait_end("after_midwait", 3000);
    repeat (5) @(negedge clk);
    keep_stale = 1'b0;
    chk("stale_done_before_start", int'(get_dn(0) > rst_cyc && get_dn(0) < get_st(0)), 1);
    chk("midwait_latency", get_st(0) - rst_cyc, SETTLE + 1);
    chk("midwait_stream", int'(stream_enable), 1);
    chk("midwait_leftover", exp_q.size(), 0);

`ifdef CODEC_VOLUME_EN
    begin : volume
      int low_cnt;
      low_cnt = 0;
      exp_q.push_back(16'h0579);
      exp_q.push_back(16'h0779);
      @(negedge clk);
      vol_level = 7'h79;
      vol_req   = 1'b1;
      @(negedge clk);
      vol_req = 1'b0;
      n = 0;
      while (n < 400) begin
        @(negedge clk);
        if (stream_enable !== 1'b1) low_cnt++;
        n++;
      end
      chk("vol_stream_held", low_cnt, 0);
      chk("vol_leftover", exp_q.size(), 0);
      chk("vol_reg_index", int'(reg_index), 8);
      exp_q.push_back(16'h0510);
      exp_q.push_back(16'h0710);
      exp_q.push_back(16'h0530);
      exp_q.push_back(16'h0730);
      @(negedge clk);
      vol_level = 7'h10;
      vol_req   = 1'b1;
      @(negedge clk);
      vol_req = 1'b0;
      repeat (5) @(negedge clk);
      vol_level = 7'h20;
      vol_req   = 1'b1;
      @(negedge clk);
      vol_level = 7'h30;
      @(negedge clk);
      vol_req = 1'b0;
      repeat (500) @(negedge clk);
      chk("vol_pend_leftover", exp_q.size(), 0);
      chk("vol_pend_stream", int'(stream_enable), 1);
      chk("vol_pend_error", int'(config_error), 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
